// File: rtl/rv_pipe_pkg.sv
// Shared pipeline types and constants for the fetch stage and its neighbours.
package rv_pipe_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/if_fetch_ctrl_if.sv
// Instruction-memory request/response port: in-order, responses always accepted.
interface if_fetch_ctrl_if;
  import rv_pipe_pkg::*;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;

  modport master (output imem_req_valid, imem_req_addr,
                  input  imem_req_ready, imem_rsp_valid, imem_rsp_data);
  modport slave  (input  imem_req_valid, imem_req_addr,
                  output imem_req_ready, imem_rsp_valid, imem_rsp_data);
endinterface

// File: rtl/if_fetch_ctrl_fetch_fifo.sv
// Small synchronous FIFO with flush; head is read straight from the storage registers.
module fetch_fifo #(
  parameter int  DEPTH = 2,
  parameter type T     = rv_pipe_pkg::fetch_entry_t
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  T                           push_data,
  input  logic                       pop,
  output T                           head,
  output logic [$clog2(DEPTH+1)-1:0] occ,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  T              mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic          full, do_push, do_pop;

  assign empty   = (occ == '0);
  assign full    = (occ == CW'(DEPTH));
  assign do_pop  = pop && !empty && !flush;
  // A pop frees the slot in the same cycle, so a full FIFO can still take a push.
  assign do_push = push && (!full || do_pop) && !flush;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      occ <= occ + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch control: PC, in-order imem requests, response buffer, redirect flush.
// Define FETCH_BYPASS_EN for a zero-latency response path when the buffer is empty.
module if_fetch_ctrl
  import rv_pipe_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  if_fetch_ctrl_if.master        bus,
  input  logic                   redirect_valid,
  input  logic [XLEN-1:0]        redirect_pc,
  input  logic                   ifid_write,
  output logic [XLEN-1:0]        instruction,
  output logic [XLEN-1:0]        pc_out,
  output logic                   instr_valid
);
  localparam int CW = $clog2(FIFO_DEPTH+1);

  logic [XLEN-1:0] pc;
  logic [CW-1:0]   inflight, discard, occ, pcq_occ_unused;
  logic            empty, pcq_empty_unused;
  fetch_entry_t    head;
  logic [XLEN-1:0] pcq_head;
  logic            issue, rsp_live, byp_hit, byp_take, fifo_push, fifo_pop;

  // Credit limit: in-flight plus buffered words never exceed the buffer size.
  assign bus.imem_req_valid = rst_n && !redirect_valid &&
                              ((int'(inflight) + int'(occ)) < FIFO_DEPTH);
  assign bus.imem_req_addr  = pc;
  assign issue              = bus.imem_req_valid && bus.imem_req_ready;
  assign rsp_live           = bus.imem_rsp_valid && (discard == '0) && !redirect_valid;

`ifdef FETCH_BYPASS_EN
  assign byp_hit = rsp_live && empty;
`else
  assign byp_hit = 1'b0;
`endif
  assign byp_take  = byp_hit && ifid_write;
  assign fifo_push = rsp_live && !byp_take;
  assign fifo_pop  = !empty && ifid_write && !redirect_valid;

  assign instr_valid = !empty || byp_hit;
  assign instruction = !empty ? head.instr : (byp_hit ? bus.imem_rsp_data : NOP_INSTR);
  assign pc_out      = !empty ? head.pc    : (byp_hit ? pcq_head          : '0);

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .T(fetch_entry_t)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (fifo_push),
    .push_data ('{pc: pcq_head, instr: bus.imem_rsp_data}),
    .pop       (fifo_pop),
    .head      (head),
    .occ       (occ),
    .empty     (empty)
  );

  // Stale responses were flushed from this queue already, so they must not pop it.
  fetch_fifo #(.DEPTH(FIFO_DEPTH), .T(logic [XLEN-1:0])) u_pcq (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (issue),
    .push_data (pc),
    .pop       (bus.imem_rsp_valid && (discard == '0)),
    .head      (pcq_head),
    .occ       (pcq_occ_unused),
    .empty     (pcq_empty_unused)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      inflight <= '0;
      discard  <= '0;
    end else begin
      inflight <= inflight + CW'(issue) - CW'(bus.imem_rsp_valid);
      if (redirect_valid) begin
        pc      <= redirect_pc;
        discard <= inflight - CW'(bus.imem_rsp_valid);
      end else begin
        if (issue) pc <= pc + PC_STEP;
        if (bus.imem_rsp_valid && (discard != '0)) discard <= discard - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl: memory model, stream-level reference model, literal checks.
module tb_if_fetch_ctrl;
  import rv_pipe_pkg::*;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;
`ifdef FETCH_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid, ifid_write;
  logic [31:0] redirect_pc;
  logic [31:0] instruction, pc_out;
  logic        instr_valid;

  if_fetch_ctrl_if bus();

  if_fetch_ctrl #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ifid_write     (ifid_write),
    .instruction    (instruction),
    .pc_out         (pc_out),
    .instr_valid    (instr_valid)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hC0DE_0001;
  endfunction

  // Memory: accepts requests, answers in order after mem_lat cycles.
  int          mem_lat = 1;
  int          cyc = 0;
  logic [31:0] mq_addr[$];
  int          mq_due[$];

  initial begin
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && bus.imem_req_valid && bus.imem_req_ready) begin
        mq_addr.push_back(bus.imem_req_addr);
        mq_due.push_back(cyc + mem_lat);
      end
      @(posedge clk); #1;
      cyc++;
      if (rst_n !== 1'b1) begin
        mq_addr.delete();
        mq_due.delete();
      end
      if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = memf(mq_addr.pop_front());
        void'(mq_due.pop_front());
      end else begin
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'hDEAD_BEEF;
      end
    end
  end

  // Reference model: expected request/consume address streams plus occupancy bookkeeping.
  logic [31:0] m_req, m_head, m_hold_addr;
  int          m_inf, m_occ, m_stale;
  bit          m_post_redir, m_hold;

  always @(negedge clk) begin
    bit ev_v, hs, rsp, cons;
    if (rst_n !== 1'b1) begin
      chk("rst_req_valid", bus.imem_req_valid, 0);
      chk("rst_req_addr", bus.imem_req_addr, RPC);
      chk("rst_instr_valid", instr_valid, 0);
      chk("rst_instruction", instruction, NOP_INSTR);
      chk("rst_pc_out", pc_out, 0);
      m_req = RPC; m_head = RPC; m_inf = 0; m_occ = 0; m_stale = 0;
      m_post_redir = 0; m_hold = 0; m_hold_addr = 0;
    end else begin
      ev_v = (m_occ > 0) ||
             (BYP == 1 && bus.imem_rsp_valid && m_stale == 0 && !redirect_valid);
      chk("m_instr_valid", instr_valid, ev_v);
      if (m_post_redir) chk("m_post_redirect_invalid", instr_valid, 0);
      if (instr_valid) begin
        chk("m_pc_out", pc_out, m_head);
        chk("m_instruction", instruction, memf(m_head));
      end else begin
        chk("m_nop", instruction, NOP_INSTR);
        chk("m_pc_zero", pc_out, 0);
      end
      chk("m_req_valid", bus.imem_req_valid, !redirect_valid && (m_inf + m_occ < DEPTH));
      if (bus.imem_req_valid) chk("m_req_addr", bus.imem_req_addr, m_req);
      if (m_hold && !redirect_valid) chk("m_req_hold", bus.imem_req_addr, m_hold_addr);

      hs   = bus.imem_req_valid && bus.imem_req_ready;
      rsp  = bus.imem_rsp_valid;
      cons = instr_valid && ifid_write && !redirect_valid;
      m_hold       = bus.imem_req_valid && !bus.imem_req_ready;
      m_hold_addr  = bus.imem_req_addr;
      m_post_redir = redirect_valid;
      if (redirect_valid) begin
        m_stale = m_inf - (rsp ? 1 : 0);
        m_inf   = m_stale;
        m_occ   = 0;
        m_req   = redirect_pc;
        m_head  = redirect_pc;
      end else begin
        if (hs) begin m_inf++; m_req += 32'd4; end
        if (rsp) begin
          m_inf--;
          if (m_stale > 0) m_stale--;
          else m_occ++;
        end
        if (cons) begin m_occ--; m_head += 32'd4; end
      end
    end
  end

  task automatic wait_valid(input string name, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (instr_valid) seen = 1;
    end
    if (!seen) chk({name, "_timeout"}, 0, 1);
  endtask

  initial begin
    int hs_cnt;
    rst_n = 1'b0;
    bus.imem_req_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    ifid_write = 1'b1;
    repeat (3) @(negedge clk);
    chk("lit_rst_addr", bus.imem_req_addr, 32'h0);
    chk("lit_rst_instr", instruction, 32'h0000_0013);

    // Reset release, zero-wait memory, continuous consume
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk); chk("c0_req_valid", bus.imem_req_valid, 1); chk("c0_addr", bus.imem_req_addr, 32'h0);
    @(negedge clk); chk("c1_addr", bus.imem_req_addr, 32'h4);
    @(negedge clk); chk("c2_addr", bus.imem_req_addr, 32'h8);
    chk("c2_valid", instr_valid, 1); chk("c2_pc", pc_out, 32'(4*BYP));
    @(negedge clk); chk("c3_valid", instr_valid, 1); chk("c3_pc", pc_out, 32'(4 + 4*BYP));
    @(negedge clk); chk("c4_valid", instr_valid, 1); chk("c4_pc", pc_out, 32'(8 + 4*BYP));

    // Consumer stall: request credit must run out
    @(posedge clk); #1 ifid_write = 1'b0;
    hs_cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.imem_req_valid && bus.imem_req_ready) hs_cnt++;
    end
    chk("stall_reqs_le_depth", hs_cnt <= DEPTH, 1);
    chk("stall_req_valid_low", bus.imem_req_valid, 0);
    chk("stall_head_valid", instr_valid, 1);
    @(posedge clk); #1 ifid_write = 1'b1;
    repeat (8) @(negedge clk);

    // Redirect to 0x8 while memory is not ready
    @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = 32'h8; bus.imem_req_ready = 1'b0;
    @(negedge clk); chk("redir8_no_req", bus.imem_req_valid, 0);
    @(posedge clk); #1 redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) chk("redir8_next_invalid", instr_valid, 0);
      chk("hold_valid", bus.imem_req_valid, 1);
      chk("hold_addr", bus.imem_req_addr, 32'h8);
    end
    @(posedge clk); #1 bus.imem_req_ready = 1'b1;
    @(negedge clk); chk("hold_release_addr", bus.imem_req_addr, 32'h8);
    @(negedge clk); chk("hold_next_addr", bus.imem_req_addr, 32'hC);
    repeat (4) @(negedge clk);

    // Two-cycle memory, redirect with two requests in flight
    mem_lat = 2;
    repeat (8) @(negedge clk);
    @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = 32'h100;
    @(negedge clk); chk("redir100_inflight", mq_addr.size() + int'(bus.imem_rsp_valid), 2);
    @(posedge clk); #1 redirect_valid = 1'b0;
    wait_valid("redir100", 20);
    chk("redir100_pc", pc_out, 32'h100);
    chk("redir100_instr", instruction, 32'hC0DE_0101);
    mem_lat = 1;
    repeat (6) @(negedge clk);

    // Redirect, response and consume in one cycle, target at the top of the address space
    @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk); chk("wrap_redir_rsp", bus.imem_rsp_valid, 1); chk("wrap_redir_head", instr_valid, 1);
    @(posedge clk); #1 redirect_valid = 1'b0;
    @(negedge clk);
    chk("wrap_invalid", instr_valid, 0); chk("wrap_nop", instruction, 32'h0000_0013);
    chk("wrap_req_valid", bus.imem_req_valid, 1); chk("wrap_addr0", bus.imem_req_addr, 32'hFFFF_FFFC);
    @(negedge clk); chk("wrap_addr1", bus.imem_req_addr, 32'h0);
    wait_valid("wrap", 20);
    chk("wrap_pc0", pc_out, 32'hFFFF_FFFC);
    @(negedge clk); chk("wrap_pc1", pc_out, 32'h0);
    repeat (3) @(negedge clk);

    // Asynchronous reset mid-cycle
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("arst_valid", instr_valid, 0); chk("arst_req_valid", bus.imem_req_valid, 0);
    chk("arst_addr", bus.imem_req_addr, RPC); chk("arst_pc_out", pc_out, 0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk); chk("rerun_req_valid", bus.imem_req_valid, 1); chk("rerun_addr", bus.imem_req_addr, 32'h0);
    repeat (8) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
